instr_fetch_queue: RTL and testbench

//  Front-end stage directly upstream of the single-cycle datapath's decode/register-read logic.

---
 rtl/instr_fetch_queue_pkg.sv | 22 ++
 rtl/instr_fetch_queue_if.sv | 33 +++
 rtl/instr_fetch_queue_sync_fifo.sv | 53 +++++
 rtl/instr_fetch_queue.sv | 112 +++++++++++
 tb/tb_instr_fetch_queue.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Holds the FSM state encoding, the FIFO entry layout and a PC alignment helper.
package instr_fetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [0:0] {
    IFQ_RUN   = 1'b0,
    IFQ_FLUSH = 1'b1
  } ifq_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Memory-side and decode-side handshake bundle of the instruction fetch queue.
// All handshakes: a transfer happens at a rising edge where the sender's valid
// (mem_req_o / mem_rvalid_i / instr_valid_o) and the receiver's accept
// (mem_gnt_i / always / instr_ready_i) are both 1; payload is held while valid waits.
interface instr_fetch_queue_if;

  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] pc_plus4_o;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output instr_valid_o, instr_o, instr_pc_o, pc_plus4_o,
    input  instr_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  instr_valid_o, instr_o, instr_pc_o, pc_plus4_o,
    output instr_ready_i
  );

endinterface

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Small synchronous FIFO holding {pc, instr} fetch entries.
// Clear wins over push and pop; pop on empty and push on full (without pop) are ignored.
module instr_fetch_queue_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = storage[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (rst_i && !clear_i && do_push) storage[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues word fetches under a credit limit, buffers
// responses with their PC, and flushes stale in-flight fetches on redirect.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic                       align_err_o,
  output ifq_state_e                 state_o,
  instr_fetch_queue_if.master        bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(ifq_entry_t);

  ifq_state_e     state_q, state_d;
  logic [31:0]    fetch_pc_q;
  logic [31:0]    resp_pc_q;
  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic           align_err_q;

  logic [CW-1:0]  fifo_count;
  logic           fifo_empty, fifo_full;
  logic [EW-1:0]  fifo_head_raw;
  ifq_entry_t     fifo_head;
  logic [CW:0]    credit_used;
  logic           gnt_take, resp_take, push, pop;

  // Entries in the FIFO plus fetches in flight may never exceed DEPTH, so a
  // response always finds room.
  assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign bus.mem_req_o = rst_i && (state_q == IFQ_RUN) && !redirect_i
                         && (credit_used < (CW+1)'(DEPTH));
  assign bus.mem_addr_o = fetch_pc_q;

  assign gnt_take  = bus.mem_req_o && bus.mem_gnt_i;
  assign resp_take = bus.mem_rvalid_i && (outstanding_q != '0);
  assign push      = resp_take && (state_q == IFQ_RUN) && !redirect_i;
  assign pop       = !fifo_empty && bus.instr_ready_i && !redirect_i;

  always_comb begin
    outstanding_d = outstanding_q + CW'(gnt_take) - CW'(resp_take);
    state_d       = state_q;
    if (redirect_i) begin
      state_d = (outstanding_d != '0) ? IFQ_FLUSH : IFQ_RUN;
    end else if (state_q == IFQ_FLUSH && outstanding_d == '0) begin
      state_d = IFQ_RUN;
    end
  end

  // resp_pc tracks the PC of the oldest live pending fetch; stale responses
  // drained in FLUSH never advance it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= IFQ_RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      align_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      align_err_q   <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
      if (redirect_i) begin
        fetch_pc_q <= word_align(redirect_pc_i);
        resp_pc_q  <= word_align(redirect_pc_i);
      end else begin
        if (gnt_take) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (push)     resp_pc_q  <= resp_pc_q + 32'd4;
      end
    end
  end

  instr_fetch_queue_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i ({resp_pc_q, bus.mem_rdata_i}),
    .pop_i       (pop),
    .clear_i     (redirect_i),
    .head_o      (fifo_head_raw),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign fifo_head         = ifq_entry_t'(fifo_head_raw);
  assign bus.instr_valid_o = !fifo_empty;
  assign bus.instr_o       = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign bus.instr_pc_o    = fifo_head.pc;
  assign bus.pc_plus4_o    = fifo_head.pc + 32'd4;
  assign align_err_o       = align_err_q;
  assign state_o           = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      assert (!(bus.mem_rvalid_i && outstanding_q == '0))
        else $error("mem_rvalid_i with no outstanding fetch");
      assert (!(push && fifo_full && !pop))
        else $error("response pushed into a full queue");
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: an in-order memory model, a
// transaction-level expected queue and a monitor comparing delivered entries.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        align_err;
  ifq_state_e  state;

  instr_fetch_queue_if bus();

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .align_err_o   (align_err),
    .state_o       (state),
    .bus           (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
  } pend_t;

  pend_t       mem_q[$];   // fetches granted and not yet answered, in order
  logic [63:0] exp_q[$];   // {pc, instr} expected at the decode interface
  int          tests = 0;
  int          fails = 0;
  int          epoch = 0;
  logic [31:0] exp_pc = 32'h0;
  logic        exp_align = 1'b0;
  logic [31:0] tgt_tab[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit stale_pending();
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- driver (one call per clock) ----------------
  task automatic drive_cycle(input bit rst_v, input int p_redir, input int p_ready,
                             input int p_rvalid, input int p_gnt);
    bit    exp_req;
    bit    stale;
    pend_t p;
    @(negedge clk);
    rst_n    = rst_v;
    redirect = rst_v && ($urandom_range(99) < p_redir);
    if (redirect) redirect_pc = ($urandom_range(1) == 0) ? tgt_tab[$urandom_range(3)] : $urandom;
    bus.instr_ready_i = ($urandom_range(99) < p_ready);
    bus.mem_rvalid_i  = (mem_q.size() != 0 || !rst_v) && ($urandom_range(99) < p_rvalid);
    bus.mem_rdata_i   = (mem_q.size() != 0) ? mem_q[0].data : $urandom;
    #1;
    bus.mem_gnt_i = ($urandom_range(99) < p_gnt);

    // Outputs must match the model before this edge takes effect.
    stale   = stale_pending();
    exp_req = rst_v && !stale && !redirect && (exp_q.size() + mem_q.size() < DEPTH);
    check("mem_req", {31'b0, bus.mem_req_o}, {31'b0, exp_req});
    if (exp_req) check("mem_addr", bus.mem_addr_o, exp_pc);
    check("instr_valid", {31'b0, bus.instr_valid_o}, {31'b0, exp_q.size() != 0});
    check("align_err", {31'b0, align_err}, {31'b0, exp_align});
    check("state", {31'b0, state}, {31'b0, stale});

    if (!rst_v) begin
      mem_q.delete();
      exp_q.delete();
      epoch++;
      exp_pc    = 32'h0;
      exp_align = 1'b0;
      return;
    end

    exp_align = redirect && (redirect_pc[1:0] != 2'b00);
    if (bus.mem_rvalid_i) begin
      p = mem_q.pop_front();
      if (p.epoch == epoch && !redirect) exp_q.push_back({p.addr, p.data});
    end
    if (redirect) begin
      exp_q.delete();
      epoch++;
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
    if (bus.mem_req_o && bus.mem_gnt_i) begin
      mem_q.push_back('{addr: exp_pc, data: $urandom, epoch: epoch});
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && !redirect && bus.instr_valid_o && bus.instr_ready_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop: got pc %h expected no entry at %0t", bus.instr_pc_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("instr", bus.instr_o, e[31:0]);
          check("instr_pc", bus.instr_pc_o, e[63:32]);
          check("pc_plus4", bus.pc_plus4_o, e[63:32] + 32'd4);
        end
      end
    end
  end

  // ---------------- stimulus phases and report ----------------
  typedef struct {
    int cycles;
    int p_redir;
    int p_ready;
    int p_rvalid;
    int p_gnt;
  } phase_t;

  phase_t phases[6];

  initial begin
    tgt_tab[0] = 32'h0000_0040;
    tgt_tab[1] = 32'h0000_0042;
    tgt_tab[2] = 32'hFFFF_FFFC;
    tgt_tab[3] = 32'hFFFF_FFFE;
    phases[0] = '{cycles: 200, p_redir: 0,  p_ready: 100, p_rvalid: 100, p_gnt: 100};
    phases[1] = '{cycles: 40,  p_redir: 0,  p_ready: 0,   p_rvalid: 100, p_gnt: 100};
    phases[2] = '{cycles: 100, p_redir: 0,  p_ready: 100, p_rvalid: 100, p_gnt: 100};
    phases[3] = '{cycles: 400, p_redir: 8,  p_ready: 70,  p_rvalid: 60,  p_gnt: 70};
    phases[4] = '{cycles: 400, p_redir: 25, p_ready: 50,  p_rvalid: 40,  p_gnt: 50};
    phases[5] = '{cycles: 300, p_redir: 5,  p_ready: 90,  p_rvalid: 30,  p_gnt: 90};

    bus.instr_ready_i = 1'b0;
    bus.mem_gnt_i     = 1'b0;
    bus.mem_rvalid_i  = 1'b0;
    bus.mem_rdata_i   = 32'h0;

    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 0, 0, 0, 0);
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < phases[ph].cycles; c++)
        drive_cycle(1'b1, phases[ph].p_redir, phases[ph].p_ready,
                    phases[ph].p_rvalid, phases[ph].p_gnt);
      // Reset in the middle of traffic, with responses possibly in flight.
      if (ph == 3) for (int i = 0; i < 2; i++) drive_cycle(1'b0, 0, 50, 50, 50);
    end
    for (int c = 0; c < 20; c++) drive_cycle(1'b1, 0, 100, 100, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
